pong_match_ctrl: RTL and testbench

Parametrised match controller for the Pong game, replacing the fixed point-scoring state machine in the top level. It watches ball and paddle positions on the 40x30 game grid, detects misses, keeps both scores, declares a match winner at a configurable limit and handles serve timing between points. It sits between the ball and paddle controllers and the video/score-draw logic, and drives `o_Game_Active` to the ball controller.

---
 rtl/pong_match_ctrl_if.sv | 30 +++
 rtl/pong_match_ctrl.sv | 155 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Match-controller bundle: ball/paddle/start inputs towards the controller and score/state outputs back.
// The game side drives through master; the controller attaches as slave.
interface pong_match_ctrl_if #(
    parameter int COORD_W = 6,
    parameter int SCORE_W = 4
);
    logic               i_Game_Start;
    logic               i_Frame_Tick;
    logic [COORD_W-1:0] i_Ball_X;
    logic [COORD_W-1:0] i_Ball_Y;
    logic [COORD_W-1:0] i_Paddle_Y_P1;
    logic [COORD_W-1:0] i_Paddle_Y_P2;
    logic               o_Game_Active;
    logic [SCORE_W-1:0] o_P1_Score;
    logic [SCORE_W-1:0] o_P2_Score;
    logic               o_Point_Pulse;
    logic               o_Match_Over;
    logic               o_Winner;
    logic [2:0]         o_State;

    modport master (
        output i_Game_Start, i_Frame_Tick, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
        input  o_Game_Active, o_P1_Score, o_P2_Score, o_Point_Pulse, o_Match_Over, o_Winner, o_State
    );

    modport slave (
        input  i_Game_Start, i_Frame_Tick, i_Ball_X, i_Ball_Y, i_Paddle_Y_P1, i_Paddle_Y_P2,
        output o_Game_Active, o_P1_Score, o_P2_Score, o_Point_Pulse, o_Match_Over, o_Winner, o_State
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: miss detection, scoring, match win and serve timing; PONG_SERVE_DELAY_EN adds the timed serve wait.
// Start edge to RUNNING in 2 clocks, miss to point 1 clock; all outputs registered or decoded from state.
module pong_match_ctrl #(
    parameter int GAME_WIDTH    = 40,
    parameter int PADDLE_HEIGHT = 6,
    parameter int COORD_W       = 6,
    parameter int SCORE_LIMIT   = 9,
    parameter int SCORE_W       = 4,
    parameter int SERVE_FRAMES  = 60
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUNNING    = 3'd1,
        ST_POINT_P1   = 3'd2,
        ST_POINT_P2   = 3'd3,
        ST_SERVE_WAIT = 3'd4,
        ST_MATCH_OVER = 3'd5
    } state_t;

    localparam logic [COORD_W:0]   PAD_SPAN  = (COORD_W+1)'(PADDLE_HEIGHT - 1);
    localparam logic [COORD_W-1:0] P2_COL    = COORD_W'(GAME_WIDTH - 1);
    localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_LIMIT);

    state_t             state, state_nxt;
    logic               start_q, start_dly, start_edge;
    logic [SCORE_W-1:0] p1_score, p2_score;
    logic               winner;
    logic               p1_inc, p2_inc, score_clr, win_set, win_val;
    logic               p1_miss, p2_miss;
    logic [COORD_W:0]   ball_y_ext, p1_top, p2_top, p1_bot, p2_bot;

    assign start_edge = start_q & ~start_dly;

    // One extra bit so a paddle near the bottom edge cannot wrap its bottom row to a small value.
    assign ball_y_ext = {1'b0, bus.i_Ball_Y};
    assign p1_top     = {1'b0, bus.i_Paddle_Y_P1};
    assign p2_top     = {1'b0, bus.i_Paddle_Y_P2};
    assign p1_bot     = p1_top + PAD_SPAN;
    assign p2_bot     = p2_top + PAD_SPAN;
    assign p1_miss    = (bus.i_Ball_X == '0) && ((ball_y_ext < p1_top) || (ball_y_ext > p1_bot));
    assign p2_miss    = (bus.i_Ball_X == P2_COL) && ((ball_y_ext < p2_top) || (ball_y_ext > p2_bot));

`ifdef PONG_SERVE_DELAY_EN
    localparam int             CNT_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    logic [CNT_W-1:0] frame_cnt;
    logic             cnt_clr, cnt_inc;
    localparam state_t AFTER_POINT = ST_SERVE_WAIT;
`else
    logic unused_frame_tick;
    assign unused_frame_tick = bus.i_Frame_Tick;
    localparam state_t AFTER_POINT = ST_IDLE;
`endif

    always_comb begin
        state_nxt = state;
        p1_inc    = 1'b0;
        p2_inc    = 1'b0;
        score_clr = 1'b0;
        win_set   = 1'b0;
        win_val   = 1'b0;
`ifdef PONG_SERVE_DELAY_EN
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start_edge) state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                // P1 miss takes priority when both ends coincide (single-column grid).
                if (p1_miss) begin
                    state_nxt = ST_POINT_P2;
                    p2_inc    = 1'b1;
                end else if (p2_miss) begin
                    state_nxt = ST_POINT_P1;
                    p1_inc    = 1'b1;
                end
            end
            ST_POINT_P1, ST_POINT_P2: begin
                if (((state == ST_POINT_P1) ? p1_score : p2_score) == SCORE_LIM) begin
                    state_nxt = ST_MATCH_OVER;
                    win_set   = 1'b1;
                    win_val   = (state == ST_POINT_P2);
                end else begin
                    state_nxt = AFTER_POINT;
`ifdef PONG_SERVE_DELAY_EN
                    cnt_clr   = 1'b1;
`endif
                end
            end
`ifdef PONG_SERVE_DELAY_EN
            ST_SERVE_WAIT: begin
                if (bus.i_Frame_Tick) begin
                    if (frame_cnt == SERVE_LAST) state_nxt = ST_RUNNING;
                    else                         cnt_inc   = 1'b1;
                end
            end
`endif
            ST_MATCH_OVER: begin
                if (start_edge) begin
                    state_nxt = ST_RUNNING;
                    score_clr = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            start_dly <= 1'b0;
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= bus.i_Game_Start;
            start_dly <= start_q;
            if (score_clr) begin
                p1_score <= '0;
                p2_score <= '0;
                winner   <= 1'b0;
            end else begin
                if (p1_inc && p1_score != SCORE_LIM) p1_score <= p1_score + SCORE_W'(1);
                if (p2_inc && p2_score != SCORE_LIM) p2_score <= p2_score + SCORE_W'(1);
                if (win_set) winner <= win_val;
            end
        end
    end

`ifdef PONG_SERVE_DELAY_EN
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)     frame_cnt <= '0;
        else if (cnt_clr) frame_cnt <= '0;
        else if (cnt_inc) frame_cnt <= frame_cnt + CNT_W'(1);
    end
`endif

    assign bus.o_Game_Active = (state == ST_RUNNING);
    assign bus.o_Point_Pulse = (state == ST_POINT_P1) || (state == ST_POINT_P2);
    assign bus.o_Match_Over  = (state == ST_MATCH_OVER);
    assign bus.o_Winner      = winner;
    assign bus.o_P1_Score    = p1_score;
    assign bus.o_P2_Score    = p2_score;
    assign bus.o_State       = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: point events are queued as expected records when a miss is driven and retired on o_Point_Pulse.
module tb_pong_match_ctrl;
    localparam int GW = 40, PH = 6, CW = 6, LIM = 2, SW = 4, SF = 3;
`ifdef PONG_SERVE_DELAY_EN
    localparam int AFTER_PT = 4;
`else
    localparam int AFTER_PT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pong_match_ctrl_if #(.COORD_W(CW), .SCORE_W(SW)) bus ();

    pong_match_ctrl #(
        .GAME_WIDTH(GW), .PADDLE_HEIGHT(PH), .COORD_W(CW),
        .SCORE_LIMIT(LIM), .SCORE_W(SW), .SERVE_FRAMES(SF)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int p1;
        int p2;
        int nxt;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_p1     = 0;
    int   m_p2     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic park_ball();
        bus.i_Ball_X = CW'(20);
        bus.i_Ball_Y = CW'(5);
    endtask

    // Retire one expected record per point pulse; the state after the point is checked a cycle later.
    always begin
        @(negedge clk);
        if (rst_n && bus.o_Point_Pulse) begin
            if (exp_q.size() == 0) begin
                chk("pulse_expected", 32'(bus.o_Point_Pulse), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_p1_score", 32'(bus.o_P1_Score), 32'(e.p1));
                chk("sb_p2_score", 32'(bus.o_P2_Score), 32'(e.p2));
                @(negedge clk);
                chk("sb_next_state", 32'(bus.o_State), 32'(e.nxt));
                if (e.nxt == 5) chk("sb_winner", 32'(bus.o_Winner), 32'(e.win));
            end
        end
    end

    task automatic do_miss(input bit p1_misses, input int y);
        exp_t e;
        if (p1_misses) m_p2++;
        else           m_p1++;
        e.p1  = m_p1;
        e.p2  = m_p2;
        e.win = p1_misses ? 1 : 0;
        e.nxt = (m_p1 == LIM || m_p2 == LIM) ? 5 : AFTER_PT;
        exp_q.push_back(e);
        bus.i_Ball_X = p1_misses ? CW'(0) : CW'(GW - 1);
        bus.i_Ball_Y = CW'(y);
        @(negedge clk);
        chk("point_state", 32'(bus.o_State), p1_misses ? 32'd3 : 32'd2);
        chk("active_drop", 32'(bus.o_Game_Active), 32'd0);
        park_ball();
        @(negedge clk);
        chk("pulse_len", 32'(bus.o_Point_Pulse), 32'd0);
    endtask

    task automatic resume();
`ifdef PONG_SERVE_DELAY_EN
        for (int i = 0; i < SF; i++) begin
            bus.i_Frame_Tick = 1'b1;
            if (i < SF - 1) bus.i_Game_Start = 1'b1;
            @(negedge clk);
            bus.i_Frame_Tick = 1'b0;
            bus.i_Game_Start = 1'b0;
            if (i < SF - 1) chk("serve_wait", 32'(bus.o_State), 32'd4);
            else            chk("serve_done", 32'(bus.o_State), 32'd1);
            @(negedge clk);
        end
`else
        repeat (2) @(negedge clk);
        bus.i_Game_Start = 1'b1;
        @(negedge clk);
        chk("resume_wait", 32'(bus.o_State), 32'd0);
        @(negedge clk);
        chk("resume_run", 32'(bus.o_State), 32'd1);
        bus.i_Game_Start = 1'b0;
`endif
    endtask

    task automatic restart_from_over();
        bus.i_Game_Start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_state", 32'(bus.o_State), 32'd1);
        chk("restart_p1", 32'(bus.o_P1_Score), 32'd0);
        chk("restart_p2", 32'(bus.o_P2_Score), 32'd0);
        m_p1 = 0;
        m_p2 = 0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_state"},  32'(bus.o_State), 32'd0);
        chk({pfx, "_p1"},     32'(bus.o_P1_Score), 32'd0);
        chk({pfx, "_p2"},     32'(bus.o_P2_Score), 32'd0);
        chk({pfx, "_active"}, 32'(bus.o_Game_Active), 32'd0);
        chk({pfx, "_pulse"},  32'(bus.o_Point_Pulse), 32'd0);
        chk({pfx, "_over"},   32'(bus.o_Match_Over), 32'd0);
        chk({pfx, "_winner"}, 32'(bus.o_Winner), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_Game_Start  = 1'b0;
        bus.i_Frame_Tick  = 1'b0;
        bus.i_Paddle_Y_P1 = CW'(10);
        bus.i_Paddle_Y_P2 = CW'(10);
        park_ball();
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");

        rst_n = 1'b1;
        @(negedge clk);
        bus.i_Game_Start = 1'b1;
        @(negedge clk);
        chk("start_lat1", 32'(bus.o_Game_Active), 32'd0);
        @(negedge clk);
        chk("start_lat2", 32'(bus.o_Game_Active), 32'd1);
        chk("start_p1", 32'(bus.o_P1_Score), 32'd0);
        chk("start_p2", 32'(bus.o_P2_Score), 32'd0);
        bus.i_Game_Start = 1'b0;

        // Paddle rows 10..15 inclusive must all be hits on both sides.
        bus.i_Ball_X = CW'(0);
        bus.i_Ball_Y = CW'(10);
        @(negedge clk); chk("hit_p1_top", 32'(bus.o_State), 32'd1);
        bus.i_Ball_Y = CW'(15);
        @(negedge clk); chk("hit_p1_bot", 32'(bus.o_State), 32'd1);
        bus.i_Ball_X = CW'(GW - 1);
        bus.i_Ball_Y = CW'(10);
        @(negedge clk); chk("hit_p2_top", 32'(bus.o_State), 32'd1);
        bus.i_Ball_Y = CW'(15);
        @(negedge clk); chk("hit_p2_bot", 32'(bus.o_State), 32'd1);
        park_ball();
        @(negedge clk);

        do_miss(1'b1, 9);
        resume();
        do_miss(1'b0, 0);
        resume();
        do_miss(1'b1, 16);
        repeat (3) @(negedge clk);
        chk("over_hold", 32'(bus.o_Match_Over), 32'd1);
        chk("over_winner", 32'(bus.o_Winner), 32'd1);
        chk("over_p1", 32'(bus.o_P1_Score), 32'd1);
        chk("over_p2", 32'(bus.o_P2_Score), 32'd2);

        // Start stays held across the next point: no second start event may follow.
        restart_from_over();
        do_miss(1'b0, 0);
`ifndef PONG_SERVE_DELAY_EN
        repeat (4) @(negedge clk);
        chk("no_repeat", 32'(bus.o_State), 32'd0);
`endif
        bus.i_Game_Start = 1'b0;
        resume();
        do_miss(1'b0, 0);
        @(negedge clk);
        chk("p1_win_over", 32'(bus.o_Match_Over), 32'd1);
        chk("p1_win_winner", 32'(bus.o_Winner), 32'd0);
        chk("p1_win_score", 32'(bus.o_P1_Score), 32'd2);

        restart_from_over();
        bus.i_Game_Start = 1'b0;
        do_miss(1'b0, 0);
        resume();
        do_miss(1'b1, 9);
        chk("pre_rst_p1", 32'(bus.o_P1_Score), 32'd1);
        chk("pre_rst_p2", 32'(bus.o_P2_Score), 32'd1);
        chk("pre_rst_state", 32'(bus.o_State), 32'(AFTER_PT));
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
